// File: rtl/linear_predictor.sv
// Linear predictor: y_hat = b_0 + b_1 * X in Q.FRAC fixed point.
// It uses a two-stage pipeline and emits a residual and a running sum of squared errors.
`timescale 1ns/1ps
module linear_predictor #(
    parameter int N_SAMPLES = 150,
    parameter int DW        = 20,
    parameter int FRAC      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [19:0]   b_0_in,
    input  logic [19:0]   b_1_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] Vect_X,
    input  logic [DW-1:0] Vect_Y,
    output logic          out_valid,
    output logic [31:0]   y_hat,
    output logic [32:0]   residual,
    output logic [63:0]   sse,
    output logic [7:0]    count,
    output logic          done
);

    // Product width: 20-bit signed slope times (DW+1)-bit zero-extended sample.
    localparam int PW   = DW + 21;
    localparam int SW   = PW + 1;
    localparam int YPAD = 33 - DW - FRAC;

    localparam logic signed [SW-1:0] SAT_MAX = SW'(64'sh7FFF_FFFF);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-64'sh8000_0000);
    localparam logic [7:0]           N_MAX   = 8'(N_SAMPLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic signed [19:0]     b_0_q, b_0_d;
    logic signed [19:0]     b_1_q, b_1_d;
    logic [7:0]             acc_q, acc_d;
    logic                   in_ready_q, in_ready_d;
    logic                   v1_q, v1_d;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic [DW-1:0]          y1_q, y1_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [31:0]     y_hat_q, y_hat_d;
    logic signed [32:0]     residual_q, residual_d;
    logic [63:0]            sse_q, sse_d;
    logic [7:0]             count_q, count_d;
    logic                   done_q, done_d;

    logic                   transfer;
    logic signed [SW-1:0]   sum_s;
    logic signed [31:0]     y_sat;
    logic signed [32:0]     y_scaled;
    logic signed [32:0]     residual_c;
    logic signed [65:0]     sq;
    logic [65:0]            sq_scaled;
    logic [66:0]            sse_sum;

    // Stage-2 arithmetic: saturating prediction, residual and the sse increment.
    always_comb begin
        sum_s = SW'(b_0_q) + SW'(prod_q);
        if (sum_s > SAT_MAX) begin
            y_sat = 32'sh7FFF_FFFF;
        end else if (sum_s < SAT_MIN) begin
            y_sat = -32'sh8000_0000;
        end else begin
            y_sat = sum_s[31:0];
        end
        y_scaled   = $signed({{YPAD{1'b0}}, y1_q, {FRAC{1'b0}}});
        residual_c = y_scaled - 33'(y_sat);
        sq         = 66'(residual_c) * 66'(residual_c);
        sq_scaled  = $unsigned(sq) >> (2 * FRAC);
        sse_sum    = 67'(sse_q) + 67'(sq_scaled);
    end

    // Next-state logic for the control FSM, the pipeline stages and the accumulators.
    always_comb begin
        state_d     = state_q;
        b_0_d       = b_0_q;
        b_1_d       = b_1_q;
        acc_d       = acc_q;
        v1_d        = 1'b0;
        prod_d      = prod_q;
        y1_d        = y1_q;
        out_valid_d = v1_q;
        y_hat_d     = y_hat_q;
        residual_d  = residual_q;
        sse_d       = sse_q;
        count_d     = count_q;
        done_d      = done_q;

        transfer = in_valid && in_ready_q;

        if (transfer) begin
            v1_d   = 1'b1;
            prod_d = PW'(b_1_q) * PW'($signed({1'b0, Vect_X}));
            y1_d   = Vect_Y;
        end

        if (v1_q) begin
            y_hat_d    = y_sat;
            residual_d = residual_c;
            count_d    = count_q + 8'd1;
            if (|sse_sum[66:64]) begin
                sse_d = '1;
            end else begin
                sse_d = sse_sum[63:0];
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    b_0_d   = b_0_in;
                    b_1_d   = b_1_in;
                    acc_d   = 8'd0;
                    sse_d   = 64'd0;
                    count_d = 8'd0;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (transfer) begin
                    acc_d = acc_q + 8'd1;
                end
                if (count_q == N_MAX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == RUN) && (acc_d < N_MAX);
    end

    // Register every piece of state; reset empties the pipeline and returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            b_0_q       <= '0;
            b_1_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            v1_q        <= 1'b0;
            prod_q      <= '0;
            y1_q        <= '0;
            out_valid_q <= 1'b0;
            y_hat_q     <= '0;
            residual_q  <= '0;
            sse_q       <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_0_q       <= b_0_d;
            b_1_q       <= b_1_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            v1_q        <= v1_d;
            prod_q      <= prod_d;
            y1_q        <= y1_d;
            out_valid_q <= out_valid_d;
            y_hat_q     <= y_hat_d;
            residual_q  <= residual_d;
            sse_q       <= sse_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_hat     = y_hat_q;
    assign residual  = residual_q;
    assign sse       = sse_q;
    assign count     = count_q;
    assign done      = done_q;

endmodule

// File: doc/linear_predictor.md
LINEAR_PREDICTOR -- requirements
Module: linear_predictor

Interface
REQ-001 Parameter N_SAMPLES, default 150: number of X/Y pairs evaluated per run.
REQ-002 Parameter DW, default 20: width of the Vect_X and Vect_Y samples.
REQ-003 Parameter FRAC, default 10: fractional bits of the coefficients, y_hat and residual (Q.FRAC).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 load  in  1  one-cycle pulse; latches b_0_in and b_1_in and starts a run.
REQ-007 b_0_in  in  20  intercept, signed Q9.10.
REQ-008 b_1_in  in  20  slope, signed Q9.10.
REQ-009 in_valid  in  1  a Vect_X/Vect_Y pair is presented.
REQ-010 in_ready  out  1  block accepts a pair this cycle.
REQ-011 Vect_X, Vect_Y  in  DW each  unsigned integer samples.
REQ-012 out_valid  out  1  y_hat and residual are valid this cycle (single-cycle pulse per sample).
REQ-013 y_hat  out  32  predicted Y, signed Q21.10.
REQ-014 residual  out  33  (Vect_Y << FRAC) - y_hat, signed Q22.10.
REQ-015 sse  out  64  running sum of squared residuals, unsigned integer.
REQ-016 count  out  8  number of results emitted in the current run.
REQ-017 done  out  1  run complete; held high until the next load or rst.

Function
REQ-018 The FSM shall have three states, IDLE, RUN and DONE; rst forces IDLE.
REQ-019 In IDLE or DONE, load shall latch both coefficients, clear sse, count and done, and enter RUN on the next cycle.
REQ-020 A load in RUN shall be ignored: coefficients, counters and the pipeline are unaffected.
REQ-021 in_ready shall be high only in RUN while accepted-pair count < N_SAMPLES.
REQ-022 A transfer occurs when in_valid && in_ready; in_valid without in_ready shall be ignored and not stall state.
REQ-023 Stage 1, registered: product = b_1 (signed) * Vect_X (zero-extended), 41 bits; Vect_Y delayed alongside.
REQ-024 Stage 2, registered: y_hat = sat32(b_0 sign-extended + product); residual = (Vect_Y << FRAC) - y_hat.
REQ-025 out_valid shall assert exactly 2 cycles after the accepting edge, once per accepted pair; pairs may be accepted back-to-back every cycle.
REQ-026 The 32-bit saturation shall clamp to 0x7FFFFFFF or 0x80000000, never wrap.
REQ-027 On each out_valid, sse shall increase by (residual*residual) >> (2*FRAC), saturating at 2^64-1; count shall increment.
REQ-028 When count reaches N_SAMPLES (after the final out_valid), the FSM shall enter DONE and assert done on the next cycle.
REQ-029 No output backpressure: results are presented for one cycle only.
REQ-030 y_hat and residual shall hold their last value when out_valid is low.

Reset
REQ-031 rst shall clear all outputs, coefficients, pipeline valid bits and counters to 0, and set the FSM to IDLE in the same edge.
REQ-032 rst mid-run shall discard in-flight pipeline data; no out_valid shall follow the reset edge.
REQ-033 rst shall take priority over a simultaneous load.

Verification
REQ-034 Basic: load b_0=0x00400 (1.0), b_1=0x00800 (2.0), then X=5, Y=12 -> 2 cycles later y_hat=0x2C00, residual=0x400, sse=1, count=1.
REQ-035 Streaming: N_SAMPLES=150 pairs on consecutive cycles with Y=2X+1 and the coefficients of REQ-034 -> 150 out_valid pulses, every residual=0, sse=0, done high on the cycle after the 150th result, in_ready low after 150 accepts.
REQ-036 Saturation: b_1=0x7FFFF, b_0=0, X=0xFFFFF -> y_hat=0x7FFFFFFF; b_1=0x80000, b_0=0x80000, X=0xFFFFF -> y_hat=0x80000000.
REQ-037 Ignored load: a load with new coefficients issued after 10 accepts -> the remaining results use the original coefficients and count still reaches 150.
REQ-038 Mid-run reset: rst asserted while 2 pairs are in flight -> no out_valid afterwards; all outputs 0 and in_ready low until the next load.
REQ-039 Gapped input: in_valid toggling every other cycle -> the result sequence equals the back-to-back case of REQ-035, and done is reached.
